muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit with architectural HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Operand/result bundle between the register file and the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Signed ops run on magnitudes; signs are restored in a single FIX cycle.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [W-1:0]    m_q, m_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_lo_q, neg_lo_d;
  logic            neg_hi_q, neg_hi_d;
  logic            div0_q, div0_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  // Operand magnitudes and result signs captured at launch
  logic            op_signed;
  logic            sign_a, sign_b;
  logic [W-1:0]    mag_a, mag_b;

  assign op_signed = ~bus.op[0];
  assign sign_a    = op_signed & bus.a[W-1];
  assign sign_b    = op_signed & bus.b[W-1];
  assign mag_a     = sign_a ? (~bus.a + W'(1)) : bus.a;
  assign mag_b     = sign_b ? (~bus.b + W'(1)) : bus.b;

  // One radix-2 step: shift-add for multiply, restoring subtract for divide
  logic [W:0]      mul_sum;
  logic [W:0]      div_diff;

  assign mul_sum  = (W+1)'(acc_q[2*W-1:W]) + (W+1)'(acc_q[0] ? m_q : W'(0));
  assign div_diff = acc_q[2*W-1:W-1] - (W+1)'(m_q);

  // Sign-corrected result presented at the FIX edge
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix, rem_fix;
  logic [W-1:0]    res_hi, res_lo;

  assign prod_fix = neg_lo_q ? (~acc_q + (2*W)'(1)) : acc_q;
  assign quo_fix  = div0_q ? {W{1'b1}}
                  : (neg_lo_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0]);
  assign rem_fix  = neg_hi_q ? (~acc_q[2*W-1:W] + W'(1)) : acc_q[2*W-1:W];
  assign res_hi   = op_q[1] ? rem_fix : prod_fix[2*W-1:W];
  assign res_lo   = op_q[1] ? quo_fix : prod_fix[W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      div0_q   <= div0_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  logic launch;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    m_d      = m_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    launch   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          launch = 1'b1;
        end else begin
          if (bus.mthi) hi_d = bus.wdata;
          if (bus.mtlo) lo_d = bus.wdata;
        end
      end
      S_RUN: begin
        if (op_q[1]) begin
          if (!div_diff[W]) acc_d = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
          else              acc_d = {acc_q[2*W-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W-1)) state_d = S_FIX;
      end
      S_FIX: begin
        hi_d    = res_hi;
        lo_d    = res_lo;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        // Back-to-back launch is allowed on the result edge
        if (bus.start) launch = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (launch) begin
      state_d  = S_RUN;
      busy_d   = 1'b1;
      op_d     = bus.op;
      cnt_d    = '0;
      div0_d   = bus.op[1] & (bus.b == W'(0));
      neg_lo_d = sign_a ^ sign_b;
      neg_hi_d = bus.op[1] ? sign_a : (sign_a ^ sign_b);
      if (bus.op[1]) begin
        acc_d = {W'(0), mag_a};
        m_d   = mag_b;
      end else begin
        acc_d = {W'(0), mag_b};
        m_d   = mag_a;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;

  localparam int unsigned W   = 32;
  localparam int unsigned LAT = W + 1;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  muldiv_unit_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference {hi,lo} from the architectural definition of each op
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin
        q = sx * sy;
        p = q;
      end
      2'b01: p = {32'd0, x} * {32'd0, y};
      default: begin
        if (y == 32'd0) begin
          p = {x, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end else begin
          p = {x % y, x / y};
        end
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Present an op for one edge, then scramble operands (only the start edge matters)
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    bus.op    = o;
    bus.a     = x;
    bus.b     = y;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    bus.op    = 2'($urandom_range(0, 3));
  endtask

  // Count edges until done; flag any busy drop or hi/lo change before it
  task automatic wait_done(output int n, output bit ok);
    logic [63:0] held;
    held = {bus.hi, bus.lo};
    n  = 0;
    ok = 1'b1;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done) break;
      if (!bus.busy || ({bus.hi, bus.lo} !== held)) ok = 1'b0;
    end
    if (n >= 200) ok = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] x,
                           input logic [31:0] y);
    logic [63:0] exp;
    int n;
    bit ok;
    exp = model(o, x, y);
    launch(o, x, y);
    wait_done(n, ok);
    chk({tag, " latency"}, 64'(n), 64'(LAT));
    chk({tag, " busy/hold"}, 64'(ok), 64'd1);
    chk({tag, " hilo"}, {bus.hi, bus.lo}, exp);
    chk({tag, " busy@done"}, 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    chk({tag, " done pulse"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [63:0] exp, prev;
    logic [1:0]  o;
    logic [31:0] x, y;
    int n;
    bit ok;

    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.mthi  = 1'b0;
    bus.mtlo  = 1'b0;
    bus.wdata = '0;
    #12;
    chk("reset state", {28'd0, bus.busy, bus.done, 2'b00, bus.hi}, 64'd0);
    chk("reset lo", 64'(bus.lo), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed corner operations
    run_check("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_check("mult -3*5", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
    run_check("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
    run_check("divu by0", 2'b11, 32'h0000_0007, 32'h0000_0000);
    run_check("div by0 neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0000);
    run_check("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run_check("mult minsq", 2'b00, 32'h8000_0000, 32'h8000_0000);

    // Second start while busy is dropped
    exp = model(2'b01, 32'h0001_0003, 32'h0000_0007);
    launch(2'b01, 32'h0001_0003, 32'h0000_0007);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.op    = 2'b11;
    bus.a     = 32'd100;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(n, ok);
    chk("ignored start latency", 64'(n), 64'(LAT - 5));
    chk("ignored start result", {bus.hi, bus.lo}, exp);
    @(posedge clk);
    #1;
    chk("ignored start idle", {62'd0, bus.busy, bus.done}, 64'd0);

    // MTHI/MTLO while idle, separately and together
    bus.mthi  = 1'b1;
    bus.wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    chk("mthi", 64'(bus.hi), 64'h1234_5678);
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    bus.mtlo = 1'b0;
    chk("mtlo", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("mthi+mtlo", {bus.hi, bus.lo}, 64'h0BAD_F00D_0BAD_F00D);

    // start and mt* together: start wins
    prev = {bus.hi, bus.lo};
    exp  = model(2'b11, 32'd50, 32'd7);
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    launch(2'b11, 32'd50, 32'd7);
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    chk("start beats mt", {bus.hi, bus.lo}, prev);
    // MTLO during busy is ignored
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    bus.mtlo = 1'b0;
    chk("mtlo while busy", 64'(bus.lo), 64'(prev[31:0]));
    wait_done(n, ok);
    chk("after mt-drop result", {bus.hi, bus.lo}, exp);

    // Back-to-back: new start on the result edge
    exp = model(2'b00, 32'hFFFF_FF00, 32'h0000_1234);
    launch(2'b00, 32'hFFFF_FF00, 32'h0000_1234);
    repeat (LAT - 1) begin
      @(posedge clk);
      #1;
    end
    bus.op    = 2'b10;
    bus.a     = 32'd1000;
    bus.b     = 32'hFFFF_FFF9;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b first result", {bus.hi, bus.lo}, exp);
    chk("b2b done+busy", {62'd0, bus.busy, bus.done}, 64'd3);
    exp = model(2'b10, 32'd1000, 32'hFFFF_FFF9);
    wait_done(n, ok);
    chk("b2b second latency", 64'(n), 64'(LAT));
    chk("b2b second result", {bus.hi, bus.lo}, exp);

    // Async reset mid-divide aborts with no done pulse
    bus.mthi  = 1'b1;
    bus.mtlo  = 1'b1;
    bus.wdata = 32'h1111_2222;
    @(posedge clk);
    #1;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    launch(2'b11, 32'hFFFF_0000, 32'd3);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy/done", {62'd0, bus.busy, bus.done}, 64'd0);
    chk("abort hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) ok = 1'b0;
    end
    chk("no done after abort", 64'(ok), 64'd1);
    run_check("post-reset divu", 2'b11, 32'hFFFF_0000, 32'd3);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = pick();
      y = pick();
      run_check($sformatf("rand%0d op%0d %h %h", i, o, x, y), o, x, y);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
